// File: rtl/axi_pkg.sv
// Shared AXI4 definitions for the burst master and the responder blocks:
// response codes, burst type codes, the AxSIZE encoder and the master FSM
// state type.
package axi_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_ADDR,
        ST_WR_DATA,
        ST_WR_RESP,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_DONE
    } master_state_t;

    // AxSIZE encoding: log2 of the number of bytes per beat.
    function automatic logic [2:0] axsize_of(input int unsigned bytes);
        logic [2:0] enc;
        enc = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd1 << i) == bytes) enc = 3'(i);
        end
        return enc;
    endfunction

endpackage

// File: rtl/axi_burst_master.sv
// AXI4 burst master: converts one command into a single INCR burst on the
// write or read channels, one transaction outstanding at a time.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   cmd_*                       command handshake and fields (write, addr, len, id)
//   wr_data/wr_strb/wr_valid/wr_ready   write beat stream in (pass-through to W)
//   rd_data/rd_resp/rd_last/rd_valid/rd_ready  read beat stream out (pass-through from R)
//   done_*                      completion record handshake
//   aw*/w*/b*/ar*/r*            AXI4 manager channels
import axi_pkg::*;

module axi_burst_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [7:0]              cmd_len,
    input  logic [ID_WIDTH-1:0]     cmd_id,

    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_strb,
    input  logic                    wr_valid,
    output logic                    wr_ready,

    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic [1:0]              rd_resp,
    output logic                    rd_last,
    output logic                    rd_valid,
    input  logic                    rd_ready,

    output logic                    done_valid,
    input  logic                    done_ready,
    output logic                    done_write,
    output logic [ID_WIDTH-1:0]     done_id,
    output logic [1:0]              done_resp,
    output logic                    done_err,

    output logic [ID_WIDTH-1:0]     awid,
    output logic [ADDR_WIDTH-1:0]   awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,

    output logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,

    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,

    output logic [ID_WIDTH-1:0]     arid,
    output logic [ADDR_WIDTH-1:0]   araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,

    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam logic [2:0]  BEAT_SIZE  = axsize_of(STRB_WIDTH);

    master_state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [7:0]            lat_len;
    logic [ID_WIDTH-1:0]   lat_id;
    logic                  lat_write;
    logic [7:0]            beat_cnt;
    logic [1:0]            resp_acc;
    logic                  err_acc;

    logic cmd_hs, w_hs, b_hs, r_hs, at_last;

    assign cmd_hs  = cmd_valid & cmd_ready;
    assign w_hs    = wvalid & wready;
    assign b_hs    = bvalid & bready;
    assign r_hs    = rvalid & rready;
    assign at_last = (beat_cnt == lat_len);

    // Address channels present the latched command; valid comes from state only.
    assign awid    = lat_id;
    assign awaddr  = lat_addr;
    assign awlen   = lat_len;
    assign awsize  = BEAT_SIZE;
    assign awburst = INCR;
    assign arid    = lat_id;
    assign araddr  = lat_addr;
    assign arlen   = lat_len;
    assign arsize  = BEAT_SIZE;
    assign arburst = INCR;

    assign done_write = lat_write;
    assign done_id    = lat_id;
    assign done_resp  = resp_acc;
    assign done_err   = err_acc;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:    if (cmd_hs)          state_nxt = cmd_write ? ST_WR_ADDR : ST_RD_ADDR;
            ST_WR_ADDR: if (awready)         state_nxt = ST_WR_DATA;
            ST_WR_DATA: if (w_hs && at_last) state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (bvalid)          state_nxt = ST_DONE;
            ST_RD_ADDR: if (arready)         state_nxt = ST_RD_DATA;
            // Exit is driven by the beat count, not by rlast; a bad rlast only flags an error.
            ST_RD_DATA: if (r_hs && at_last) state_nxt = ST_DONE;
            ST_DONE:    if (done_ready)      state_nxt = ST_IDLE;
            default:                         state_nxt = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        cmd_ready  = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        wdata      = '0;
        wstrb      = '0;
        wlast      = 1'b0;
        wr_ready   = 1'b0;
        bready     = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        rd_resp    = '0;
        rd_last    = 1'b0;
        done_valid = 1'b0;
        unique case (state)
            // Gated by reset so every ready output is low while reset is held.
            ST_IDLE:    cmd_ready = ~reset;
            ST_WR_ADDR: awvalid = 1'b1;
            ST_WR_DATA: begin
                wvalid   = wr_valid;
                wdata    = wr_data;
                wstrb    = wr_strb;
                wlast    = at_last;
                wr_ready = wready;
            end
            ST_WR_RESP: bready = 1'b1;
            ST_RD_ADDR: arvalid = 1'b1;
            ST_RD_DATA: begin
                rd_valid = rvalid;
                rd_data  = rdata;
                rd_resp  = rresp;
                rd_last  = rlast;
                rready   = rd_ready;
            end
            ST_DONE:    done_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latch, beat counter and completion accumulation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_addr  <= '0;
            lat_len   <= '0;
            lat_id    <= '0;
            lat_write <= 1'b0;
            beat_cnt  <= '0;
            resp_acc  <= OKAY;
            err_acc   <= 1'b0;
        end else begin
            if (cmd_hs) begin
                lat_addr  <= cmd_addr;
                lat_len   <= cmd_len;
                lat_id    <= cmd_id;
                lat_write <= cmd_write;
                beat_cnt  <= '0;
                resp_acc  <= OKAY;
                err_acc   <= 1'b0;
            end
            // Counter holds on the final beat so len = 255 never wraps.
            if (w_hs && !at_last) beat_cnt <= beat_cnt + 8'd1;
            if (b_hs) begin
                resp_acc <= bresp;
                err_acc  <= (bid != lat_id);
            end
            if (r_hs) begin
                if (!at_last) beat_cnt <= beat_cnt + 8'd1;
                if (rresp > resp_acc) resp_acc <= rresp;
                if ((rid != lat_id) || (rlast != at_last)) err_acc <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_master.sv
// Self-checking bench for axi_burst_master: a table of directed commands with
// hand-computed completion records, randomized commands checked against a
// spec-level reference model, and a hand-written reset-mid-burst sequence.
module tb_axi_burst_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;
    localparam int SW = DW / 8;

    logic clk = 1'b0;
    logic reset;

    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [7:0]    cmd_len;
    logic [IW-1:0] cmd_id;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          wr_valid, wr_ready;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;
    logic          rd_last, rd_valid, rd_ready;
    logic          done_valid, done_ready, done_write, done_err;
    logic [IW-1:0] done_id;
    logic [1:0]    done_resp;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [AW-1:0] awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [SW-1:0] wstrb;

    always #5 clk = ~clk;

    axi_burst_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_ready(done_ready), .done_write(done_write),
        .done_id(done_id), .done_resp(done_resp), .done_err(done_err),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Per-beat stimulus for the responder and the write stream (one spare beat
    // beyond len so over-acceptance on R can be detected).
    logic [DW-1:0] wbeat   [257];
    logic [SW-1:0] sbeat   [257];
    logic [DW-1:0] rbeat   [257];
    logic [1:0]    rresp_b [257];
    logic          rlast_b [257];
    logic [IW-1:0] rid_b   [257];
    logic [IW-1:0] b_id;
    logic [1:0]    b_resp;
    int unsigned   delay;
    bit            bp, rnd;

    // Reference model: completion record from the AXI rules.
    function automatic logic [1:0] model_resp(input bit wr, input int unsigned nb);
        logic [1:0] worst;
        if (wr) return b_resp;
        worst = 2'b00;
        for (int unsigned i = 0; i < nb; i++)
            if (rresp_b[i] > worst) worst = rresp_b[i];
        return worst;
    endfunction

    function automatic bit model_err(input bit wr, input logic [IW-1:0] id, input int unsigned nb);
        if (wr) return (b_id != id);
        for (int unsigned i = 0; i < nb; i++)
            if ((rid_b[i] != id) || (rlast_b[i] != (i == nb - 1))) return 1'b1;
        return 1'b0;
    endfunction

    task automatic quiesce();
        cmd_valid = 0; wr_valid = 0; bvalid = 0; rvalid = 0; awready = 0;
        arready = 0; wready = 0; rd_ready = 0; done_ready = 0;
    endtask

    task automatic run_txn(input string tag, input bit wr, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [IW-1:0] id,
                           output logic [1:0] got_resp, output logic got_err);
        int unsigned nb, cyc, wi, wo, ri, vcnt, idx;
        int unsigned stab_err, data_err, last_err, cr_err, early_w;
        bit sent, a_done, w_done, b_done, fin, acc_prev;
        logic [63:0] exp_f, act_f;
        logic got_write;
        logic [IW-1:0] got_id;
        nb = int'(len) + 1;
        cyc = 0; wi = 0; wo = 0; ri = 0; vcnt = 0;
        stab_err = 0; data_err = 0; last_err = 0; cr_err = 0; early_w = 0;
        sent = 0; a_done = 0; w_done = 0; b_done = 0; fin = 0; acc_prev = 0;
        got_resp = 2'b00; got_err = 1'b0; got_write = 1'b0; got_id = '0;
        exp_f = {15'd0, addr, len, id, 3'd2, 2'b01};
        while (!fin && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            cmd_valid = !sent; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id;
            awready  = !a_done && (vcnt + 1 >= delay);
            arready  = !a_done && (vcnt + 1 >= delay);
            idx      = (wi > 256) ? 256 : wi;
            wr_valid = (wi < nb) && ((bp || rnd) ? ($urandom_range(0, 3) != 0) : 1'b1);
            wr_data  = wbeat[idx];
            wr_strb  = sbeat[idx];
            wready   = bp ? cyc[0] : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            bvalid   = w_done && !b_done && (rnd ? ($urandom_range(0, 2) == 0) : 1'b1);
            bid      = b_id;
            bresp    = b_resp;
            idx      = (ri > 256) ? 256 : ri;
            rvalid   = a_done && !wr && (ri <= nb) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
            rdata    = rbeat[idx];
            rresp    = rresp_b[idx];
            rlast    = rlast_b[idx];
            rid      = rid_b[idx];
            rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            done_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (acc_prev) begin
                check({tag, "_issue_latency"}, 64'(wr ? awvalid : arvalid), 64'd1);
                acc_prev = 0;
            end
            if (cmd_valid && cmd_ready) begin sent = 1; acc_prev = 1; end
            if (wvalid && !a_done) early_w++;
            if (wr ? awvalid : arvalid) begin
                act_f = wr ? {15'd0, awaddr, awlen, awid, awsize, awburst}
                           : {15'd0, araddr, arlen, arid, arsize, arburst};
                if (act_f !== exp_f) stab_err++;
                vcnt++;
                if (wr ? awready : arready) a_done = 1;
            end
            if ((wr_valid && wr_ready) != (wvalid && wready)) data_err++;
            if (wvalid && wready) begin
                if (wdata !== wbeat[wo] || wstrb !== sbeat[wo]) data_err++;
                if (wlast !== (wo == nb - 1)) last_err++;
                if (wlast) w_done = 1;
                wo++;
                wi++;
            end
            if (bvalid && bready) b_done = 1;
            if ((rd_valid && rd_ready) != (rvalid && rready)) data_err++;
            if (rvalid && rready) begin
                if (rd_data !== rbeat[idx] || rd_resp !== rresp_b[idx] || rd_last !== rlast_b[idx])
                    data_err++;
                ri++;
            end
            if (done_valid) begin
                if (cmd_ready) cr_err++;
                if (done_ready) begin
                    fin = 1;
                    got_resp = done_resp; got_err = done_err;
                    got_write = done_write; got_id = done_id;
                end
            end
        end
        @(posedge clk);
        #1;
        quiesce();
        check({tag, "_completed"}, 64'(fin), 64'd1);
        check({tag, "_addr_fields"}, 64'(stab_err), 64'd0);
        check({tag, "_addr_valid_cycles"}, 64'(vcnt), 64'(delay));
        check({tag, "_w_before_aw"}, 64'(early_w), 64'd0);
        check({tag, "_beats"}, 64'(wr ? wo : ri), 64'(nb));
        check({tag, "_payload"}, 64'(data_err), 64'd0);
        if (wr) check({tag, "_wlast_pos"}, 64'(last_err), 64'd0);
        check({tag, "_cmd_ready_in_done"}, 64'(cr_err), 64'd0);
        check({tag, "_done_write"}, 64'(got_write), 64'(wr));
        check({tag, "_done_id"}, 64'(got_id), 64'(id));
        if (!fin) begin
            reset = 1; @(negedge clk); reset = 0;
        end
    endtask

    typedef struct {
        bit          write;
        logic [31:0] addr;
        logic [7:0]  len;
        logic [3:0]  id;
        int unsigned delay;
        logic [3:0]  rsp_id;
        logic [1:0]  bresp;
        logic [1:0]  bad_rresp;   // rresp on beat index 1, OKAY elsewhere
        int          early_last;  // beat index carrying rlast, -1 = on the final beat
        bit          bp;
        logic [31:0] data0;       // beat i carries data0 + i
        logic [1:0]  exp_resp;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    task automatic prep_vec(input vec_t v);
        for (int i = 0; i < 257; i++) begin
            wbeat[i]   = v.data0 + 32'(i);
            sbeat[i]   = '1;
            rbeat[i]   = v.data0 + 32'(i);
            rresp_b[i] = (i == 1) ? v.bad_rresp : 2'b00;
            rid_b[i]   = v.rsp_id;
            rlast_b[i] = (v.early_last >= 0) ? (i == v.early_last) : (i == int'(v.len));
        end
        b_id = v.rsp_id; b_resp = v.bresp; delay = v.delay; bp = v.bp; rnd = 0;
    endtask

    logic [1:0] g_resp;
    logic       g_err;

    task automatic reset_mid_burst();
        int unsigned hs, cyc;
        bit sent, ar_done;
        hs = 0; cyc = 0; sent = 0; ar_done = 0;
        while (hs < 2 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            cmd_valid = !sent; cmd_write = 0; cmd_addr = 32'h300; cmd_len = 8'd7; cmd_id = 4'd9;
            arready = 1; rd_ready = 1;
            rvalid = ar_done; rdata = 32'(hs); rresp = 2'b00; rlast = 0; rid = 4'd9;
            #1;
            if (cmd_valid && cmd_ready) sent = 1;
            if (arvalid && arready) ar_done = 1;
            if (rvalid && rready) hs++;
        end
        check("rst_reached_beat2", 64'(hs), 64'd2);
        @(negedge clk);
        cmd_valid = 0; rvalid = 1; rdata = 32'd2;
        reset = 1;
        #1;
        check("rst_valids_low",
              64'({awvalid, wvalid, arvalid, rd_valid, done_valid, bready, rready, wr_ready, cmd_ready}),
              64'd0);
        check("rst_addr_len_zero", 64'({awaddr, araddr, awlen, arlen}), 64'd0);
        @(negedge clk);
        reset = 0;
        quiesce();
        hs = 0;
        repeat (4) begin
            @(negedge clk); #1;
            if (done_valid) hs++;
        end
        check("rst_no_completion", 64'(hs), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1, 32'h100,  8'd0,   4'd3,  1, 4'd3,  2'b00, 2'b00, -1, 0, 32'hDEADBEEF, 2'b00, 0};
        vecs[1] = '{0, 32'h200,  8'd3,   4'd1,  5, 4'd1,  2'b00, 2'b00, -1, 0, 32'h0,        2'b00, 0};
        vecs[2] = '{1, 32'h400,  8'd15,  4'd2,  1, 4'd2,  2'b00, 2'b00, -1, 1, 32'h1000,     2'b00, 0};
        vecs[3] = '{0, 32'h800,  8'd3,   4'd4,  2, 4'd4,  2'b00, 2'b10, -1, 0, 32'h50,       2'b10, 0};
        vecs[4] = '{0, 32'h800,  8'd3,   4'd4,  2, 4'd4,  2'b00, 2'b10,  1, 0, 32'h50,       2'b10, 1};
        vecs[5] = '{1, 32'hA00,  8'd0,   4'd5,  1, 4'd6,  2'b00, 2'b00, -1, 0, 32'h77,       2'b00, 1};
        vecs[6] = '{1, 32'hB00,  8'd2,   4'd7,  3, 4'd7,  2'b10, 2'b00, -1, 0, 32'h1,        2'b10, 0};
        vecs[7] = '{0, 32'hC00,  8'd1,   4'd7,  1, 4'd8,  2'b00, 2'b00, -1, 0, 32'h9,        2'b00, 1};
        vecs[8] = '{0, 32'h1000, 8'd255, 4'd10, 1, 4'd10, 2'b00, 2'b11, -1, 0, 32'h0,        2'b11, 0};
        vecs[9] = '{1, 32'h2000, 8'd255, 4'd11, 2, 4'd11, 2'b01, 2'b00, -1, 1, 32'hABC0,     2'b01, 0};

        reset = 1;
        quiesce();
        cmd_write = 0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
        wr_data = '0; wr_strb = '0; bid = '0; bresp = '0;
        rid = '0; rdata = '0; rresp = '0; rlast = 0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_valids_low",
              64'({awvalid, wvalid, arvalid, rd_valid, done_valid, bready, rready, wr_ready, cmd_ready}),
              64'd0);
        check("reset_fields_zero", 64'({awaddr, awlen, awid, wdata, araddr}), 64'd0);
        reset = 0;
        @(negedge clk);

        for (int v = 0; v < 10; v++) begin
            prep_vec(vecs[v]);
            run_txn($sformatf("vec%0d", v), vecs[v].write, vecs[v].addr, vecs[v].len,
                    vecs[v].id, g_resp, g_err);
            check($sformatf("vec%0d_done_resp", v), 64'(g_resp), 64'(vecs[v].exp_resp));
            check($sformatf("vec%0d_done_err", v), 64'(g_err), 64'(vecs[v].exp_err));
        end

        reset_mid_burst();
        prep_vec(vecs[1]);
        run_txn("post_reset", 0, 32'h200, 8'd3, 4'd1, g_resp, g_err);
        check("post_reset_done_resp", 64'(g_resp), 64'd0);
        check("post_reset_done_err", 64'(g_err), 64'd0);

        for (int t = 0; t < 40; t++) begin
            bit          wr;
            logic [7:0]  len;
            logic [3:0]  id;
            int unsigned nb, off;
            logic [31:0] addr;
            wr  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 15));
            nb  = int'(len) + 1;
            id  = 4'($urandom);
            off = $urandom_range(0, (4096 - nb * 4) / 4) * 4;
            addr = ($urandom & 32'hFFFF_F000) | 32'(off);
            for (int i = 0; i < 257; i++) begin
                wbeat[i]   = $urandom;
                sbeat[i]   = 4'($urandom);
                rbeat[i]   = $urandom;
                rresp_b[i] = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
                rid_b[i]   = ($urandom_range(0, 29) == 0) ? (id ^ 4'd1) : id;
                rlast_b[i] = (i == int'(len)) ^ ($urandom_range(0, 29) == 0);
            end
            b_id   = ($urandom_range(0, 4) == 0) ? (id + 4'd1) : id;
            b_resp = 2'($urandom);
            delay  = $urandom_range(1, 4);
            bp = 0; rnd = 1;
            run_txn($sformatf("rnd%0d", t), wr, addr, len, id, g_resp, g_err);
            check($sformatf("rnd%0d_done_resp", t), 64'(g_resp), 64'(model_resp(wr, nb)));
            check($sformatf("rnd%0d_done_err", t), 64'(g_err), 64'(model_err(wr, id, nb)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
